// File: rtl/multiword_add_seq.sv
// Serial multiword adder/subtractor: one n-bit ripple slice is reused for WORDS
// cycles to build a W = n*WORDS bit sum, least significant slice first.

module multiword_add_seq_slice #(
    parameter int n = 4
) (
    input  logic         i_ci,
    input  logic [n-1:0] i_x,
    input  logic [n-1:0] i_y,
    output logic [n-1:0] o_sum,
    output logic         o_co
);
    logic [n:0] w_c;

    assign w_c[0] = i_ci;

    genvar g;
    generate
        for (g = 0; g < n; g++) begin : g_fa
            assign o_sum[g]   = i_x[g] ^ i_y[g] ^ w_c[g];
            assign w_c[g + 1] = (i_x[g] & i_y[g]) | (w_c[g] & (i_x[g] ^ i_y[g]));
        end
    endgenerate

    assign o_co = w_c[n];
endmodule

// Handshake: start is sampled only while idle (busy=0, done=0); busy is high for
// exactly WORDS cycles, then done pulses for one cycle with S/carryout/overflow final.
module multiword_add_seq #(
    parameter int n     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sub,
    input  logic [n*WORDS-1:0]   A,
    input  logic [n*WORDS-1:0]   B,
    output logic                 busy,
    output logic                 done,
    output logic [n*WORDS-1:0]   S,
    output logic                 carryout,
    output logic                 overflow
);
    localparam int W  = n * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_s;
    logic           r_carry;
    logic           r_cout;
    logic           r_ovf;
    logic [IW-1:0]  r_idx;

    logic [n-1:0]   w_x;
    logic [n-1:0]   w_y;
    logic [n-1:0]   w_sum;
    logic           w_co;
    logic           w_c_msb;
    logic           w_last;

    assign w_x    = r_a[32'(r_idx) * n +: n];
    assign w_y    = r_b[32'(r_idx) * n +: n];
    assign w_last = (r_idx == IW'(WORDS - 1));
    // Carry into the slice MSB recovered from its sum bit and operand bits.
    assign w_c_msb = w_x[n-1] ^ w_y[n-1] ^ w_sum[n-1];

    multiword_add_seq_slice #(.n(n)) u_slice (
        .i_ci  (r_carry),
        .i_x   (w_x),
        .i_y   (w_y),
        .o_sum (w_sum),
        .o_co  (w_co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= sub ? ~B : B;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_s     <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_s[32'(r_idx) * n +: n] <= w_sum;
                    r_carry                  <= w_co;
                    if (w_last) begin
                        r_cout  <= w_co;
                        r_ovf   <= w_c_msb ^ w_co;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign S        = r_s;
    assign carryout = r_cout;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized bench for multiword_add_seq: driver pushes expected {overflow,carryout,S}
// from a whole-word arithmetic model; a negedge monitor pops and compares on done.

module tb_multiword_add_seq;
    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         carryout;
    logic         overflow;

    logic [W+1:0] exp_q[$];
    int           n_cmp;
    int           n_err;

    multiword_add_seq #(.n(N), .WORDS(WORDS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .S        (S),
        .carryout (carryout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Whole-word reference: {overflow, carryout, S}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic [W-1:0] bx;
        logic [W:0]   full;
        logic         ov;
        bx   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + (W+1)'(s);
        ov   = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full};
    endfunction

    task automatic chk(input string name, input logic ok, input logic [W+1:0] act,
                       input logic [W+1:0] req);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with S=0x%0h, required no done (t=%0t)",
                         S, $time);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                chk("result", {overflow, carryout, S} === e, {overflow, carryout, S}, e);
            end
        end
    end

    // Issue one operation from IDLE; returns in IDLE one cycle after done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic scramble, input logic [W+1:0] exp);
        int k;
        int busy_bad;
        start = 1'b1;
        A     = a;
        B     = b;
        sub   = s;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start    = 1'b0;
        sub      = 1'($urandom_range(0, 1));
        k        = 0;
        busy_bad = 0;
        while (done !== 1'b1 && k < 4 * WORDS) begin
            if (busy !== 1'b1) busy_bad++;
            if (scramble) begin
                A = W'($urandom);
                B = W'($urandom);
            end
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency_busy", k == WORDS && busy_bad == 0 && busy === 1'b0,
            (W+2)'(k * 16 + busy_bad), (W+2)'(WORDS * 16));
        if (k >= 4 * WORDS) exp_q.delete();
        @(posedge clk);
        #1;
        chk("done_one_cycle", done === 1'b0 && busy === 1'b0, (W+2)'({busy, done}), '0);
        chk("result_stable", {overflow, carryout, S} === exp, {overflow, carryout, S}, exp);
    endtask

    initial begin
        int done_at[$];
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, overflow, carryout, S} === '0,
            {overflow, carryout, S}, '0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_hold", {busy, done, overflow, carryout, S} === '0,
            {overflow, carryout, S}, '0);

        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 18'h00100);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 18'h0FFFE);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 18'h37FFF);

        // start held for 12 edges: accepts at offsets 0 and 6 only.
        A     = 16'h1234;
        B     = 16'h1111;
        sub   = 1'b0;
        start = 1'b1;
        exp_q.push_back(18'h02345);
        exp_q.push_back(18'h02345);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (i == 11) start = 1'b0;
            if (done === 1'b1) done_at.push_back(i);
        end
        chk("held_start_count", done_at.size() == 2, (W+2)'(done_at.size()), 2);
        if (done_at.size() == 2) begin
            chk("held_start_e4", done_at[0] == 4, (W+2)'(done_at[0]), 4);
            chk("held_start_e10", done_at[1] == 10, (W+2)'(done_at[1]), 10);
        end

        // Reset at E0+2 aborts; no done may follow.
        start = 1'b1;
        A     = 16'h1234;
        B     = 16'h1111;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_state", {busy, done, overflow, carryout, S} === '0,
            (W+2)'({busy, done, overflow, carryout, S}), '0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_quiet", {busy, done, S} === '0, (W+2)'({busy, done, S}), '0);
        do_op(16'h1234, 16'h1111, 1'b0, 1'b1, 18'h02345);

        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         s;
            logic [W-1:0] corner[4];
            corner[0] = 16'h0000;
            corner[1] = 16'hFFFF;
            corner[2] = 16'h8000;
            corner[3] = 16'h7FFF;
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            s = 1'($urandom_range(0, 1));
            do_op(a, b, s, 1'($urandom_range(0, 1)), model(a, b, s));
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size() == 0, (W+2)'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
